// File: rtl/text_port_arbiter_pkg.sv
// Shared definitions for the .text read-port arbiter: response-owner encoding
// and default address width.
package text_port_arbiter_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 12;
    localparam int SCNT_W             = 4;

    typedef enum logic [1:0] {
        OWN_IDLE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DATA  = 2'd2
    } own_e;

endpackage

// File: rtl/text_port_arbiter_if.sv
// Bundle of the fetch, data and text-memory signals around the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface text_port_arbiter_if
    import text_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);

    logic                  f_req;
    logic [ADDR_WIDTH-1:0] f_addr;
    logic                  f_gnt;
    logic                  f_rvalid;
    logic [31:0]           f_rdata;

    logic                  d_req;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [31:0]           d_rdata;

    logic                  m_en;
    logic [ADDR_WIDTH-1:0] m_addr;
    logic [31:0]           m_dout;

    modport slave (
        input  f_req, f_addr, d_req, d_addr, m_dout,
        output f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata, m_en, m_addr
    );

    modport master (
        output f_req, f_addr, d_req, d_addr, m_dout,
        input  f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata, m_en, m_addr
    );

endinterface

// File: rtl/text_port_arbiter.sv
// Arbitrates instruction fetch and data loads onto one synchronous-read text
// memory port: fetch has priority, data is forced through after STARVE_MAX denials.
module text_port_arbiter
    import text_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    text_port_arbiter_if.slave  port_if
);

    localparam logic [SCNT_W-1:0] STARVE_LIM = SCNT_W'(STARVE_MAX);

    own_e                  own_q, own_d;
    logic [SCNT_W-1:0]     scnt_q, scnt_d;
    logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
    logic                  d_force;
    logic                  f_gnt;
    logic                  d_gnt;

    always_comb begin
        d_force = port_if.d_req && (scnt_q == STARVE_LIM);
        f_gnt   = !rst && port_if.f_req && !d_force;
        d_gnt   = !rst && port_if.d_req && (d_force || !port_if.f_req);

        m_addr_d = m_addr_q;
        if (f_gnt)      m_addr_d = port_if.f_addr;
        else if (d_gnt) m_addr_d = port_if.d_addr;

        // The denial run restarts whenever data is granted or stops asking.
        scnt_d = '0;
        if (port_if.d_req && !d_gnt)
            scnt_d = (scnt_q == STARVE_LIM) ? scnt_q : scnt_q + 1'b1;

        own_d = OWN_IDLE;
        if (f_gnt)      own_d = OWN_FETCH;
        else if (d_gnt) own_d = OWN_DATA;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values computed above.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            own_q    <= OWN_IDLE;
            scnt_q   <= '0;
            m_addr_q <= '0;
        end else begin
            own_q    <= own_d;
            scnt_q   <= scnt_d;
            m_addr_q <= m_addr_d;
        end
    end

    assign port_if.f_gnt    = f_gnt;
    assign port_if.d_gnt    = d_gnt;
    assign port_if.m_en     = f_gnt | d_gnt;
    assign port_if.m_addr   = m_addr_d;
    assign port_if.f_rvalid = (own_q == OWN_FETCH);
    assign port_if.d_rvalid = (own_q == OWN_DATA);
    assign port_if.f_rdata  = port_if.m_dout;
    assign port_if.d_rdata  = port_if.m_dout;

endmodule

// File: tb/tb_text_port_arbiter.sv
// Randomized and directed stimulus for text_port_arbiter, checked by a grant
// model plus a response scoreboard drained by an independent monitor.
module tb_text_port_arbiter;

    localparam int AW    = 12;
    localparam int SMAX  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    text_port_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

    text_port_arbiter #(.ADDR_WIDTH(AW), .STARVE_MAX(SMAX)) dut (
        .clk     (clk),
        .rst     (rst),
        .port_if (bus)
    );

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        return 32'h9E37_79B9 * (32'(a) + 32'd1);
    endfunction

    // External synchronous-read text memory.
    always @(posedge clk) if (bus.m_en) bus.m_dout <= mem_word(bus.m_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        bit          fetch;
        logic [31:0] data;
        int          due;
    } resp_t;

    resp_t sb[$];

    // Reference model: data has waited `waited` consecutive denied cycles;
    // once that reaches SMAX it wins outright, otherwise fetch wins.
    int              waited   = 0;
    logic [AW-1:0]   last_adr = '0;
    bit              f_pend   = 0;
    bit              d_pend   = 0;

    always @(negedge clk) begin
        bit gf, gd;
        logic [AW-1:0] ea;
        if (rst) begin
            check("gnt_f_in_reset", 32'(bus.f_gnt), 32'd0);
            check("gnt_d_in_reset", 32'(bus.d_gnt), 32'd0);
            check("m_en_in_reset",  32'(bus.m_en),  32'd0);
            waited   = 0;
            last_adr = '0;
            f_pend   = 0;
            d_pend   = 0;
        end else begin
            gd = bus.d_req && (waited >= SMAX || !bus.f_req);
            gf = bus.f_req && !gd;
            ea = gf ? bus.f_addr : (gd ? bus.d_addr : last_adr);
            check("f_gnt",  32'(bus.f_gnt),  32'(gf));
            check("d_gnt",  32'(bus.d_gnt),  32'(gd));
            check("m_en",   32'(bus.m_en),   32'(gf | gd));
            check("m_addr", 32'(bus.m_addr), 32'(ea));
            if (gf || gd) sb.push_back('{fetch: gf, data: mem_word(ea), due: cyc + 1});
            last_adr = ea;
            waited   = (bus.d_req && !gd) ? ((waited < SMAX) ? waited + 1 : SMAX) : 0;
            f_pend   = bus.f_req && !gf;
            d_pend   = bus.d_req && !gd;
        end
    end

    always @(negedge clk) begin
        resp_t e;
        if (rst) begin
            check("f_rvalid_in_reset", 32'(bus.f_rvalid), 32'd0);
            check("d_rvalid_in_reset", 32'(bus.d_rvalid), 32'd0);
            sb.delete();
        end else if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check("f_rvalid", 32'(bus.f_rvalid), 32'(e.fetch));
            check("d_rvalid", 32'(bus.d_rvalid), 32'(!e.fetch));
            if (e.fetch) check("f_rdata", bus.f_rdata, e.data);
            else         check("d_rdata", bus.d_rdata, e.data);
        end else begin
            check("f_rvalid_idle", 32'(bus.f_rvalid), 32'd0);
            check("d_rvalid_idle", 32'(bus.d_rvalid), 32'd0);
        end
    end

    task automatic drive(input bit f, input int fa, input bit d, input int da);
        bus.f_req  = f;
        bus.f_addr = AW'(fa);
        bus.d_req  = d;
        bus.d_addr = AW'(da);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.f_req  = 1'b0;
        bus.f_addr = '0;
        bus.d_req  = 1'b0;
        bus.d_addr = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single fetch, then idle so its response is seen.
        drive(1, 'h010, 0, 0);
        drive(0, 0, 0, 0);

        // Both held: F,F,F,F,D repeating.
        repeat (15) drive(1, 'h040, 1, 'h200);
        drive(0, 0, 0, 0);

        // Alternating F, D, F on consecutive cycles.
        drive(1, 'h004, 0, 0);
        drive(0, 0, 1, 'h100);
        drive(1, 'h008, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);

        // Data alone is granted immediately.
        drive(0, 0, 1, 'h123);
        drive(0, 0, 0, 0);

        // Grant, then reset in the following cycle discards the response.
        drive(1, 'h020, 0, 0);
        bus.f_req = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1, 'h030, 0, 0);
        drive(0, 0, 0, 0);

        // Denial run broken by dropping d_req, then restarted from zero.
        repeat (3) drive(1, 'h050, 1, 'h300);
        drive(1, 'h050, 0, 'h300);
        repeat (6) drive(1, 'h050, 1, 'h300);
        drive(0, 0, 0, 0);

        // Random traffic; ungranted requests stay stable until granted.
        repeat (400) begin
            if (!f_pend) begin
                bus.f_req  = ($urandom_range(0, 99) < 60);
                bus.f_addr = AW'($urandom);
            end
            if (!d_pend) begin
                bus.d_req  = ($urandom_range(0, 99) < 45);
                bus.d_addr = AW'($urandom);
            end
            @(posedge clk);
            #1;
        end

        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        @(negedge clk);
        if (sb.size() != 0) check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/text_port_arbiter.md
TEXT_PORT_ARBITER -- requirements
Module: text_port_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, SHALL set the word-address width of all address ports.
REQ-002 Parameter STARVE_MAX, default 4, SHALL set the consecutive-denial limit for the data requester (legal range 1..15).
REQ-003 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 RST  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 F_REQ  input  1  SHALL be the instruction-fetch read request.
REQ-006 F_ADDR  input  ADDR_WIDTH  SHALL be the fetch word address.
REQ-007 F_GNT  output  1  SHALL indicate the fetch request is accepted this cycle.
REQ-008 F_RVALID / F_RDATA  output  1 / 32  SHALL be the fetch response strobe and instruction word.
REQ-009 D_REQ / D_ADDR  input  1 / ADDR_WIDTH  SHALL be the data-side (load from .text) read request and word address.
REQ-010 D_GNT  output  1  SHALL indicate the data request is accepted this cycle.
REQ-011 D_RVALID / D_RDATA  output  1 / 32  SHALL be the data response strobe and word.
REQ-012 M_EN / M_ADDR  output  1 / ADDR_WIDTH  SHALL drive the synchronous-read text memory port.
REQ-013 M_DOUT  input  32  SHALL be the memory read data, valid the cycle after M_EN.

Function
REQ-014 Grants SHALL be combinational from requests and state; at most one of F_GNT/D_GNT SHALL be high per cycle.
REQ-015 Default priority SHALL be fetch over data.
REQ-016 Starvation counter SCNT (4 bits) SHALL increment each cycle D_REQ=1 and D_GNT=0, saturating at STARVE_MAX, and SHALL clear on any cycle D_GNT=1 or D_REQ=0.
REQ-017 When SCNT==STARVE_MAX and D_REQ=1, D_GNT SHALL be 1 and F_GNT 0 regardless of F_REQ.
REQ-018 M_EN SHALL equal F_GNT|D_GNT; M_ADDR SHALL be F_ADDR when F_GNT, D_ADDR when D_GNT, else hold previous registered value.
REQ-019 Response owner register OWN SHALL take states IDLE, FETCH, DATA: next = FETCH on F_GNT, DATA on D_GNT, else IDLE.
REQ-020 F_RVALID SHALL be 1 exactly when OWN==FETCH; D_RVALID exactly when OWN==DATA (latency: one cycle after grant).
REQ-021 F_RDATA and D_RDATA SHALL both pass M_DOUT unmodified; consumers qualify with RVALID.
REQ-022 Back-to-back grants SHALL be sustained: one grant per cycle, throughput 1 word/cycle with no bubble on requester switch.
REQ-023 Simultaneous F_REQ and D_REQ with SCNT<STARVE_MAX SHALL grant fetch and increment SCNT.
REQ-024 A requester SHALL hold REQ and ADDR stable until granted; the block does not latch ungranted requests.

Reset
REQ-025 On RST=1, OWN SHALL become IDLE, SCNT 0, registered M_ADDR 0, immediately (asynchronous).
REQ-026 During RST, F_GNT, D_GNT, M_EN, F_RVALID, D_RVALID SHALL be 0.
REQ-027 A grant issued in the cycle before reset asserts SHALL produce no RVALID; the response is discarded.

Structure
REQ-028 OWN state encoding (IDLE=0, FETCH=1, DATA=2) and the default ADDR_WIDTH SHALL live in the shared core package.
REQ-029 The block SHALL be one flat module with no sub-modules; the memory is external and instantiated by the parent.

Verification
REQ-030 F_REQ=1 addr 0x010, D_REQ=0 -> F_GNT=1, M_ADDR=0x010; next cycle F_RVALID=1, F_RDATA=M_DOUT.
REQ-031 F_REQ and D_REQ held 1 continuously, STARVE_MAX=4 -> pattern F,F,F,F,D repeats; D_GNT every 5th cycle.
REQ-032 Alternating grants F(0x004), D(0x100), F(0x008) on consecutive cycles -> F_RVALID, D_RVALID, F_RVALID on next three cycles, each with matching data.
REQ-033 D_REQ=1 alone -> D_GNT=1 same cycle, SCNT stays 0, D_RVALID next cycle.
REQ-034 F_GNT in cycle N, RST asserted in cycle N+1 -> F_RVALID=0, OWN=IDLE, SCNT=0; after release, new request served normally.
REQ-035 D_REQ dropped at SCNT=3 then reasserted with F_REQ=1 -> SCNT restarts at 0; data granted only after 4 further denials.
